div_issue: RTL and testbench

Multi-cycle issue/retire controller that sits directly upstream of the 32-bit radix-2 divider in the EXE stage. It accepts one LoongArch divide/modulo micro-op from the pipeline over a valid/ready handshake and holds the operands stable for the divider. It waits for the divider to complete, selects quotient or remainder, and presents the result downstream. It also absorbs pipeline flushes without leaving the divider's internal iteration counter mid-count.

---
 rtl/div_issue_if.sv | 30 +++
 rtl/div_issue.sv | 134 +++++++++++++
 tb/tb_div_issue.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_issue_if.sv
// Pipeline-facing handshake bundle for div_issue.
//   in_*  : one divide/modulo micro-op offered by the pipeline (valid/ready).
//   out_* : registered result presented downstream (valid/ready).
// master : pipeline side (drives the op and out_ready).
// slave  : div_issue side (drives in_ready and the result).
interface div_issue_if;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_src1;
  logic [31:0] in_src2;
  logic [4:0]  in_dest;
  logic [31:0] in_pc;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_dest;
  logic [31:0] out_pc;

  modport master (
    output in_valid, in_op, in_src1, in_src2, in_dest, in_pc, out_ready,
    input  in_ready, out_valid, out_result, out_dest, out_pc
  );

  modport slave (
    input  in_valid, in_op, in_src1, in_src2, in_dest, in_pc, out_ready,
    output in_ready, out_valid, out_result, out_dest, out_pc
  );
endinterface

// File: rtl/div_issue.sv
// Issue/retire controller in front of the 32-bit radix-2 divider.
// Accepts one div.w/mod.w/div.wu/mod.wu op, holds its operands stable on div_x/div_y while
// div_en is high, captures quotient or remainder on completion and presents it downstream.
// A flush during the divide drains the divider to completion so its iteration counter is
// back at zero before the next op.
// Ports:
//   div_clk, resetn    : clock, asynchronous active-low reset (shared with the divider)
//   flush              : kills the in-flight op
//   pipe               : upstream op handshake and downstream result handshake
//   busy               : an op (or a drain) occupies the block
//   div_en, div_signed : divider start/hold and signedness
//   div_x, div_y       : dividend / divisor to the divider
//   div_s, div_r       : divider quotient / remainder
//   div_complete       : divider done (only meaningful while div_en=1)
module div_issue (
  input  logic        div_clk,
  input  logic        resetn,
  input  logic        flush,
  div_issue_if.slave  pipe,
  output logic        busy,
  output logic        div_en,
  output logic        div_signed,
  output logic [31:0] div_x,
  output logic [31:0] div_y,
  input  logic [31:0] div_s,
  input  logic [31:0] div_r,
  input  logic        div_complete
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e      state_q, state_d;
  logic [1:0]  op_q;
  logic [31:0] src1_q;
  logic [31:0] src2_q;
  logic [4:0]  dest_q;
  logic [31:0] pc_q;
  logic [31:0] result_q;

  logic        accept;
  logic        hold_load;
  logic        result_load;

  // in_ready must stay a function of state, out_ready and flush only.
  assign pipe.in_ready = (state_q == StIdle) ||
                         ((state_q == StDone) && pipe.out_ready && !flush);
  assign accept        = pipe.in_valid && pipe.in_ready && !flush;

  always_comb begin
    state_d     = state_q;
    hold_load   = 1'b0;
    result_load = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d   = StRun;
          hold_load = 1'b1;
        end
      end
      StRun: begin
        if (flush) begin
          // Completing this cycle means the divider counter is already back at zero.
          state_d = div_complete ? StIdle : StDrain;
        end else if (div_complete) begin
          state_d     = StDone;
          result_load = 1'b1;
        end
      end
      StDrain: begin
        if (div_complete) begin
          state_d = StIdle;
        end
      end
      StDone: begin
        if (flush) begin
          state_d = StIdle;
        end else if (pipe.out_ready) begin
          if (accept) begin
            state_d   = StRun;
            hold_load = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge div_clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge div_clk or negedge resetn) begin
    if (!resetn) begin
      op_q   <= 2'b00;
      src1_q <= '0;
      src2_q <= '0;
      dest_q <= '0;
      pc_q   <= '0;
    end else if (hold_load) begin
      op_q   <= pipe.in_op;
      src1_q <= pipe.in_src1;
      src2_q <= pipe.in_src2;
      dest_q <= pipe.in_dest;
      pc_q   <= pipe.in_pc;
    end
  end

  always_ff @(posedge div_clk or negedge resetn) begin
    if (!resetn) begin
      result_q <= '0;
    end else if (result_load) begin
      result_q <= op_q[0] ? div_r : div_s;
    end
  end

  assign div_en     = (state_q == StRun) || (state_q == StDrain);
  assign div_signed = ~op_q[1];
  assign div_x      = src1_q;
  assign div_y      = src2_q;
  assign busy       = (state_q != StIdle);

  // Holding registers only reload on the retire edge, so they still carry the tag in DONE.
  assign pipe.out_valid  = (state_q == StDone);
  assign pipe.out_result = result_q;
  assign pipe.out_dest   = dest_q;
  assign pipe.out_pc     = pc_q;

endmodule

// File: tb/tb_div_issue.sv
module tb_div_issue;

  logic        clk = 1'b0;
  logic        resetn;
  logic        flush;
  logic        busy;
  logic        div_en;
  logic        div_signed;
  logic [31:0] div_x;
  logic [31:0] div_y;
  logic [31:0] div_s;
  logic [31:0] div_r;
  logic        div_complete;

  always #5 clk = ~clk;

  div_issue_if pif ();

  div_issue dut (
    .div_clk      (clk),
    .resetn       (resetn),
    .flush        (flush),
    .pipe         (pif),
    .busy         (busy),
    .div_en       (div_en),
    .div_signed   (div_signed),
    .div_x        (div_x),
    .div_y        (div_y),
    .div_s        (div_s),
    .div_r        (div_r),
    .div_complete (div_complete)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [95:0] got, input logic [95:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- divider model: 34-cycle iteration, result valid on last cycle ----------
  function automatic logic [63:0] divider_calc(input logic sgn, input logic [31:0] x,
                                               input logic [31:0] y);
    logic [31:0] ax, ay, q, r;
    if (y == 32'd0) return {x, 32'hFFFF_FFFF};
    ax = (sgn && x[31]) ? -x : x;
    ay = (sgn && y[31]) ? -y : y;
    q  = ax / ay;
    r  = ax % ay;
    if (sgn && (x[31] ^ y[31])) q = -q;
    if (sgn && x[31]) r = -r;
    return {r, q};
  endfunction

  logic [5:0]  cnt;
  logic [63:0] div_out;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) cnt <= 6'd0;
    else if (div_en) cnt <= (cnt == 6'd33) ? 6'd0 : cnt + 6'd1;
  end

  assign div_complete = !div_en || (cnt == 6'd33);
  assign div_out      = divider_calc(div_signed, div_x, div_y);
  // Garbage outside the completion cycle so a mistimed capture shows up.
  assign div_s = (div_en && cnt == 6'd33) ? div_out[31:0]  : 32'hDEAD_BEEF;
  assign div_r = (div_en && cnt == 6'd33) ? div_out[63:32] : 32'hBADC_0FFE;

  // ---------------- reference model and scoreboard ----------------
  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  dest;
    logic [31:0] pc;
    logic        dc;    // divide by zero: value undefined
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  exp_t exp_q[$];
  int   age       = 0;  // cycles since the accept edge of the queued op
  int   drain_rem = 0;  // cycles the divider still runs after a flush

  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint q, r;
    if (!op[1]) begin
      q = longint'($signed(a)) / longint'($signed(b));
      r = longint'($signed(a)) % longint'($signed(b));
    end else begin
      q = longint'({32'd0, a}) / longint'({32'd0, b});
      r = longint'({32'd0, a}) % longint'({32'd0, b});
    end
    return op[0] ? r[31:0] : q[31:0];
  endfunction

  always @(negedge clk) begin
    logic       pend;
    logic       exp_ready;
    logic [3:0] exp_ctrl;
    exp_t       e;
    exp_t       n;
    if (!resetn) begin
      exp_q.delete();
      drain_rem = 0;
      age       = 0;
    end else begin
      pend = (exp_q.size() != 0);
      e    = '0;
      if (pend) begin
        age++;
        e = exp_q[0];
      end
      exp_ready = (!pend && drain_rem == 0) ||
                  (pend && age >= 35 && pif.out_ready && !flush);
      exp_ctrl  = {exp_ready, pend && age >= 35, pend || drain_rem > 0,
                   (pend && age <= 34) || drain_rem > 0};
      check("ctrl{in_ready,out_valid,busy,div_en}",
            96'({pif.in_ready, pif.out_valid, busy, div_en}), 96'(exp_ctrl));
      if (pend && age <= 34)
        check("operands{x,y,signed}", 96'({div_x, div_y, div_signed}),
              96'({e.a, e.b, ~e.op[1]}));
      if (pend && age >= 35) begin
        check("out_tag{dest,pc}", 96'({pif.out_dest, pif.out_pc}), 96'({e.dest, e.pc}));
        if (!e.dc) check("out_result", 96'(pif.out_result), 96'(e.res));
      end

      if (drain_rem > 0) drain_rem--;
      if (flush) begin
        if (pend) begin
          if (age < 34) drain_rem = 34 - age;
          void'(exp_q.pop_front());
        end
      end else if (pend && age >= 35 && pif.out_ready) begin
        void'(exp_q.pop_front());
      end

      if (pif.in_valid && exp_ready && !flush) begin
        n.dc   = (pif.in_src2 == 32'd0);
        n.res  = n.dc ? 32'd0 : ref_result(pif.in_op, pif.in_src1, pif.in_src2);
        n.dest = pif.in_dest;
        n.pc   = pif.in_pc;
        n.op   = pif.in_op;
        n.a    = pif.in_src1;
        n.b    = pif.in_src2;
        exp_q.push_back(n);
        age = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] d, input logic [31:0] pc);
    bit ok = 1'b0;
    pif.in_valid = 1'b1;
    pif.in_op    = op;
    pif.in_src1  = a;
    pif.in_src2  = b;
    pif.in_dest  = d;
    pif.in_pc    = pc;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (pif.in_ready && !flush) ok = 1'b1;
    end
    @(posedge clk);
    #1;
    pif.in_valid = 1'b0;
    check("issue_accepted", 96'(ok), 96'(1));
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0 && drain_rem == 0) ok = 1'b1;
    end
    @(posedge clk);
    #1;
    check("reach_idle", 96'(ok), 96'(1));
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  bit rand_done = 1'b0;

  initial begin
    resetn        = 1'b0;
    flush         = 1'b0;
    pif.in_valid  = 1'b0;
    pif.in_op     = 2'b00;
    pif.in_src1   = '0;
    pif.in_src2   = '0;
    pif.in_dest   = '0;
    pif.in_pc     = '0;
    pif.out_ready = 1'b1;
    wait_cycles(3);
    resetn = 1'b1;
    @(negedge clk);
    check("reset_out{result,dest,pc}",
          96'({pif.out_result, pif.out_dest, pif.out_pc}), 96'(0));
    wait_cycles(1);

    // Basic ops
    issue(2'b00, 32'hFFFF_FFF9, 32'h2, 5'd3, 32'h1C00_0000);
    wait_idle();
    issue(2'b11, 32'hFFFF_FFFF, 32'h10, 5'd7, 32'h1C00_0010);
    wait_idle();
    issue(2'b01, 32'hFFFF_FFF9, 32'h2, 5'd9, 32'h1C00_0020);
    wait_idle();

    // Back-to-back with out_ready=1
    issue(2'b10, 32'd1000, 32'd3, 5'd1, 32'h1C00_0100);
    issue(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd2, 32'h1C00_0104);
    wait_idle();

    // Flush 10 cycles into RUN, then a normal op after the drain
    issue(2'b00, 32'd12345, 32'd67, 5'd4, 32'h1C00_0200);
    wait_cycles(9);
    flush = 1'b1;
    wait_cycles(1);
    flush = 1'b0;
    issue(2'b10, 32'd100, 32'd7, 5'd5, 32'h1C00_0204);
    wait_idle();

    // Flush in the completion cycle
    issue(2'b01, 32'd99, 32'd10, 5'd6, 32'h1C00_0300);
    wait_cycles(33);
    flush = 1'b1;
    wait_cycles(1);
    flush = 1'b0;
    wait_idle();

    // Flush in DONE with out_ready=0
    pif.out_ready = 1'b0;
    issue(2'b10, 32'd50, 32'd5, 5'd8, 32'h1C00_0400);
    wait_cycles(36);
    flush = 1'b1;
    wait_cycles(1);
    flush = 1'b0;
    pif.out_ready = 1'b1;
    wait_idle();

    // Backpressure for 20 cycles in DONE, plus divide by zero
    pif.out_ready = 1'b0;
    issue(2'b11, 32'h1234_5678, 32'h0, 5'd10, 32'h1C00_0500);
    wait_cycles(54);
    pif.out_ready = 1'b1;
    wait_idle();

    // Asynchronous reset mid-RUN
    issue(2'b00, 32'd777, 32'd7, 5'd11, 32'h1C00_0600);
    wait_cycles(10);
    #2;
    resetn = 1'b0;
    #1;
    check("async_reset{out_valid,busy,div_en,result,dest,pc}",
          96'({pif.out_valid, busy, div_en, pif.out_result, pif.out_dest, pif.out_pc}),
          96'(0));
    wait_cycles(2);
    resetn = 1'b1;
    wait_cycles(1);

    // Randomized traffic with random backpressure and occasional flushes
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          logic [31:0] a, b;
          a = ($urandom % 8 == 0) ? 32'h8000_0000 : $urandom;
          case ($urandom % 8)
            0:       b = 32'd0;
            1:       b = $urandom % 16;
            2:       b = 32'hFFFF_FFFF;
            default: b = $urandom;
          endcase
          repeat ($urandom_range(0, 3)) @(posedge clk);
          #1;
          issue(2'($urandom), a, b, 5'($urandom), $urandom);
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          pif.out_ready = ($urandom % 4) != 0;
          flush         = ($urandom % 80) == 0;
        end
        pif.out_ready = 1'b1;
        flush         = 1'b0;
      end
    join
    wait_idle();
    wait_cycles(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
